// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: instruction-fetch stage in front of decode.
// Owns the fetch PC, issues one word fetch at a time over a req/ack handshake,
// queues returned instructions with their PC and PC+4, and hands them to decode
// over valid/ready. A redirect from execute flushes the queue and restarts fetch.
// Optional build macro FETCH_PERF_EN adds stall/flush performance counters.
module fetch_queue_stage #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [INS_W-1:0] imem_rdata,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [INS_W-1:0] id_instr,
    output logic [PC_W-1:0]  id_pc,
    output logic [PC_W-1:0]  id_pc4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_flush_cnt
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PC_W-1:0]  PC_ZERO  = {PC_W{1'b0}};
    localparam logic [PC_W-1:0]  PC_STEP  = {{(PC_W-3){1'b0}}, 3'b100};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Fetch control state
    state_t           state_r;
    logic             req_r;
    logic [PC_W-1:0]  req_addr_r;
    logic [PC_W-1:0]  fetch_pc_r;

    // Queue storage and bookkeeping
    logic [INS_W-1:0] instr_q_r [DEPTH];
    logic [PC_W-1:0]  pc_q_r    [DEPTH];
    logic [PC_W-1:0]  pc4_q_r   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Registered head presented to decode
    logic             valid_r;
    logic [INS_W-1:0] head_instr_r;
    logic [PC_W-1:0]  head_pc_r;
    logic [PC_W-1:0]  head_pc4_r;

    // Combinational helpers
    logic             pop_s;
    logic             push_s;
    logic             issue_s;
    logic [PC_W-1:0]  redirect_tgt_s;
    logic [PC_W-1:0]  fetch_pc4_s;
    logic [CNT_W-1:0] count_after_pop_s;
    logic [CNT_W-1:0] count_next_s;
    logic [PTR_W-1:0] rd_ptr_pop_s;
    logic             valid_nxt_s;
    logic             head_load_s;
    logic [INS_W-1:0] head_instr_nxt_s;
    logic [PC_W-1:0]  head_pc_nxt_s;
    logic [PC_W-1:0]  head_pc4_nxt_s;

    // Handshake decode, occupancy bookkeeping and issue gating
    always_comb begin
        pop_s             = valid_r & id_ready;
        push_s            = (state_r == ST_REQ) & imem_ack & ~redirect;
        redirect_tgt_s    = {redirect_pc[PC_W-1:2], 2'b00};
        fetch_pc4_s       = req_addr_r + PC_STEP;
        count_after_pop_s = count_r - CNT_W'(pop_s);
        rd_ptr_pop_s      = rd_ptr_r + PTR_W'(pop_s);
        // An entry leaving this cycle frees room for the fetch being issued now
        issue_s           = (state_r == ST_IDLE) & ~redirect & (count_after_pop_s < DEPTH_C);
        if (redirect) begin
            count_next_s = CNT_ZERO;
        end else begin
            count_next_s = count_after_pop_s + CNT_W'(push_s);
        end
    end

    // Next head selection: a push into an empty (after pop) queue bypasses storage
    always_comb begin
        valid_nxt_s      = 1'b0;
        head_load_s      = 1'b0;
        head_instr_nxt_s = head_instr_r;
        head_pc_nxt_s    = head_pc_r;
        head_pc4_nxt_s   = head_pc4_r;
        if (redirect) begin
            valid_nxt_s = 1'b0;
            head_load_s = 1'b0;
        end else if (count_next_s == CNT_ZERO) begin
            valid_nxt_s = 1'b0;
            head_load_s = 1'b0;
        end else begin
            valid_nxt_s = 1'b1;
            head_load_s = 1'b1;
        end
        if (count_after_pop_s == CNT_ZERO) begin
            head_instr_nxt_s = imem_rdata;
            head_pc_nxt_s    = req_addr_r;
            head_pc4_nxt_s   = fetch_pc4_s;
        end else begin
            head_instr_nxt_s = instr_q_r[rd_ptr_pop_s];
            head_pc_nxt_s    = pc_q_r[rd_ptr_pop_s];
            head_pc4_nxt_s   = pc4_q_r[rd_ptr_pop_s];
        end
    end

    // Fetch FSM: one outstanding request, redirect wins, DROP swallows a stale ack
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            req_r      <= 1'b0;
            req_addr_r <= PC_ZERO;
            fetch_pc_r <= PC_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (redirect) begin
                        fetch_pc_r <= redirect_tgt_s;
                    end else if (issue_s) begin
                        req_r      <= 1'b1;
                        req_addr_r <= fetch_pc_r;
                        state_r    <= ST_REQ;
                    end else begin
                        req_r      <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (redirect) begin
                        fetch_pc_r <= redirect_tgt_s;
                        if (imem_ack) begin
                            req_r   <= 1'b0;
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_DROP;
                        end
                    end else if (imem_ack) begin
                        fetch_pc_r <= fetch_pc4_s;
                        req_r      <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        req_r      <= 1'b1;
                    end
                end
                ST_DROP: begin
                    if (redirect) begin
                        fetch_pc_r <= redirect_tgt_s;
                    end else begin
                        fetch_pc_r <= fetch_pc_r;
                    end
                    if (imem_ack) begin
                        req_r   <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        req_r   <= 1'b1;
                    end
                end
                default: begin
                    req_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Queue storage write; contents need no reset because pointers gate visibility
    always_ff @(posedge clk) begin
        if (push_s) begin
            instr_q_r[wr_ptr_r] <= imem_rdata;
            pc_q_r[wr_ptr_r]    <= req_addr_r;
            pc4_q_r[wr_ptr_r]   <= fetch_pc4_s;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else if (redirect) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(push_s);
            rd_ptr_r <= rd_ptr_pop_s;
            count_r  <= count_next_s;
        end
    end

    // Registered head outputs; the head data holds when the queue goes empty
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r      <= 1'b0;
            head_instr_r <= {INS_W{1'b0}};
            head_pc_r    <= PC_ZERO;
            head_pc4_r   <= PC_ZERO;
        end else begin
            valid_r <= valid_nxt_s;
            if (head_load_s) begin
                head_instr_r <= head_instr_nxt_s;
                head_pc_r    <= head_pc_nxt_s;
                head_pc4_r   <= head_pc4_nxt_s;
            end
        end
    end

`ifdef FETCH_PERF_EN
    localparam logic [31:0] PERF_MAX = 32'hFFFF_FFFF;
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Saturating counters: decode starved of work, and redirects taken
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (id_ready && !valid_r && (stall_cnt_r != PERF_MAX)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if (redirect && (flush_cnt_r != PERF_MAX)) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_r;
    assign perf_flush_cnt = flush_cnt_r;
`endif

    assign imem_req  = req_r;
    assign imem_addr = req_addr_r;
    assign id_valid  = valid_r;
    assign id_instr  = head_instr_r;
    assign id_pc     = head_pc_r;
    assign id_pc4    = head_pc4_r;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: instruction memory responder with a
// programmable ack delay, directed decode-side stimulus, hand-computed expectations.
module tb_fetch_queue_stage;

    localparam int PC_W  = 9;
    localparam int INS_W = 32;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_ack;
    logic [INS_W-1:0] imem_rdata;
    logic             redirect;
    logic [PC_W-1:0]  redirect_pc;
    logic             id_valid;
    logic             id_ready;
    logic [INS_W-1:0] id_instr;
    logic [PC_W-1:0]  id_pc;
    logic [PC_W-1:0]  id_pc4;
`ifdef FETCH_PERF_EN
    logic [31:0]      perf_stall_cnt;
    logic [31:0]      perf_flush_cnt;
`endif

    int n_asserts = 0;
    int n_fail    = 0;
    int ack_delay = 1;
    int req_age   = 0;

    always #5 clk = ~clk;

    fetch_queue_stage #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc4         (id_pc4)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    // Memory contents: word i holds 32'h1000_0000 + i
    function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
        return 32'h1000_0000 + {25'd0, a[PC_W-1:2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory responder, evaluated on the falling edge
    task automatic respond();
        if (!imem_req) begin
            imem_ack = 1'b0;
            req_age  = 0;
        end else if (imem_ack) begin
            imem_ack = 1'b0;
            req_age  = 0;
        end else if (req_age >= ack_delay) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
        end else begin
            req_age++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        respond();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // which=0: wait for imem_req; which=1: wait for an ack on a live request
    task automatic wait_sig(input int which, input string tag);
        int  b;
        logic hit;
        b   = 0;
        hit = (which == 0) ? imem_req : (imem_req & imem_ack);
        while (!hit && b < 100) begin
            tick();
            b++;
            hit = (which == 0) ? imem_req : (imem_req & imem_ack);
        end
        chk({tag, "_timeout"}, 32'(hit), 32'd1);
    endtask

    // Check n consecutive decode handshakes starting at start_pc
    task automatic consume(input int n, input logic [PC_W-1:0] start_pc, input string tag);
        logic [PC_W-1:0] e;
        logic [PC_W-1:0] e4;
        int got;
        int b;
        e   = start_pc;
        got = 0;
        b   = 0;
        while (got < n && b < 200) begin
            if (id_valid && id_ready) begin
                e4 = e + 9'd4;
                chk({tag, "_pc"},    32'(id_pc),  32'(e));
                chk({tag, "_pc4"},   32'(id_pc4), 32'(e4));
                chk({tag, "_instr"}, id_instr,    mem_word(e));
                e = e4;
                got++;
            end
            tick();
            b++;
        end
        chk({tag, "_count"}, 32'(got), 32'(n));
    endtask

    initial begin
        int pushes;
        int b;
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        redirect    = 1'b0;
        redirect_pc = 9'd0;
        id_ready    = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_instr", id_instr,      32'd0);
        chk("rst_pc",    32'(id_pc),    32'd0);
        chk("rst_pc4",   32'(id_pc4),   32'd0);
`ifdef FETCH_PERF_EN
        chk("rst_stall", perf_stall_cnt, 32'd0);
        chk("rst_flush", perf_flush_cnt, 32'd0);
`endif
        reset = 1'b0;

        // 1: streaming fetch with decode always ready
        id_ready  = 1'b1;
        ack_delay = 1;
        consume(6, 9'h000, "stream");
        id_ready = 1'b0;

        // 2: decode stalls; queue fills to DEPTH and fetch stops
        do_reset();
        pushes = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req && imem_ack) pushes++;
            tick();
        end
        chk("full_pushes", 32'(pushes),   32'd4);
        chk("full_req",    32'(imem_req), 32'd0);
        chk("full_valid",  32'(id_valid), 32'd1);
        chk("full_head",   32'(id_pc),    32'h000);
        id_ready = 1'b1;
        wait_sig(0, "resume_req");
        chk("resume_addr", 32'(imem_addr), 32'h010);
        consume(4, 9'h004, "resume");
        id_ready = 1'b0;

        // 3: redirect while a request is pending; late ack is dropped
        do_reset();
        id_ready  = 1'b1;
        ack_delay = 3;
        wait_sig(0, "drop_req");
        redirect    = 1'b1;
        redirect_pc = 9'h040;
        tick();
        redirect = 1'b0;
        chk("drop_req_held",  32'(imem_req),  32'd1);
        chk("drop_addr_held", 32'(imem_addr), 32'h000);
        wait_sig(1, "drop_ack");
        tick();
        ack_delay = 1;
        wait_sig(0, "drop_next");
        chk("drop_next_addr", 32'(imem_addr), 32'h040);
        chk("drop_no_valid",  32'(id_valid),  32'd0);
        consume(2, 9'h040, "drop");
        id_ready = 1'b0;

        // 4: redirect in the same cycle as an ack with two entries queued
        do_reset();
        pushes = 0;
        b      = 0;
        while (pushes < 2 && b < 100) begin
            if (imem_req && imem_ack) pushes++;
            tick();
            b++;
        end
        wait_sig(1, "flush_ack");
        chk("flush_pre_valid", 32'(id_valid), 32'd1);
        chk("flush_pre_head",  32'(id_pc),    32'h000);
        redirect    = 1'b1;
        redirect_pc = 9'h080;
        tick();
        redirect = 1'b0;
        chk("flush_valid", 32'(id_valid), 32'd0);
        id_ready = 1'b1;
        consume(2, 9'h080, "flush");
        id_ready = 1'b0;

        // 5: back-to-back redirects, low bits forced to 0, PC wraps at 2^PC_W
        do_reset();
        id_ready    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 9'h100;
        tick();
        redirect_pc = 9'h1FB;
        tick();
        redirect = 1'b0;
        consume(3, 9'h1F8, "wrap");
        id_ready = 1'b0;

`ifdef FETCH_PERF_EN
        // 6: performance counters
        do_reset();
        chk("perf_rst_stall", perf_stall_cnt, 32'd0);
        chk("perf_rst_flush", perf_flush_cnt, 32'd0);
        ack_delay = 1000;
        id_ready  = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        id_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 9'h020;
        tick();
        tick();
        redirect = 1'b0;
        tick();
        chk("perf_stall", perf_stall_cnt, 32'd5);
        chk("perf_flush", perf_flush_cnt, 32'd2);
        do_reset();
        chk("perf_clr_stall", perf_stall_cnt, 32'd0);
        chk("perf_clr_flush", perf_flush_cnt, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
